// File: rtl/reaction_timer_multi.sv
// reaction_timer_multi: N-player reaction tester with random go-delay, false-start detection,
// first-press arbitration, best-time memory and a multiplexed BCD 7-segment display.
module reaction_timer_multi #(
  parameter int CLK_HZ       = 10000000,
  parameter int NUM_PLAYERS  = 2,
  parameter int DIGITS       = 4,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 10,
  parameter int REFRESH_DIV  = 10000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                   clk,
  input  logic                   reset_btn,
  input  logic                   start_btn,
  input  logic [NUM_PLAYERS-1:0] react_btn,
  input  logic                   show_best,
  output logic                   led,
  output logic [6:0]             seg,
  output logic [DIGITS-1:0]      an,
  output logic [NUM_PLAYERS-1:0] winner,
  output logic                   false_start,
  output logic                   best_valid
);
  localparam int PRE_DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int PW = $clog2(PRE_DIV + 1);
  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam int GW = $clog2(DIGITS);
  localparam int DMAX = MIN_DELAY_MS + (1 << RAND_BITS);
  localparam int DW = $clog2((DMAX > 251 ? DMAX : 251) + 1);
  localparam int TW = 4 * DIGITS;
  localparam logic AL = ACTIVE_LOW != 0;
  localparam logic [TW-1:0] ALL9 = {DIGITS{4'h9}};
  localparam logic [DW-1:0] BLINK_MS = DW'(250);
  localparam logic [6:0] SEG_RST = {7{AL}} ^ 7'h3F;
  localparam logic [DIGITS-1:0] AN_RST = {DIGITS{AL}} ^ DIGITS'(1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_GO, S_RESULT, S_FOUL} state_t;

  state_t                 state_q, state_d;
  logic [NUM_PLAYERS:0]   s1_q, s2_q, s3_q, e_q;
  logic [15:0]            lfsr_q;
  logic [PW-1:0]          pre_q, pre_d;
  logic [RW-1:0]          ref_q, ref_d;
  logic [GW-1:0]          dig_q, dig_d;
  logic [DW-1:0]          delay_q, delay_d;
  logic [TW-1:0]          cur_q, cur_d, best_q, best_d, cur_inc, disp;
  logic                   best_valid_q, best_valid_d, led_q, led_d, false_start_q, false_start_d;
  logic [NUM_PLAYERS-1:0] winner_q, winner_d, react_e, first;
  logic [6:0]             seg_q, seg_d, seg_hi;
  logic [DIGITS-1:0]      an_q, an_d;
  logic [3:0]             nib;
  logic                   tick, rtick, start_e, show_sel, dash, carry;

  assign tick = pre_q == PW'(PRE_DIV - 1);
  assign rtick = ref_q == RW'(REFRESH_DIV - 1);
  assign start_e = e_q[0];
  assign react_e = e_q[NUM_PLAYERS:1];
  assign first = react_e & (~react_e + NUM_PLAYERS'(1));
  assign ref_d = rtick ? '0 : ref_q + RW'(1);
  assign dig_d = !rtick ? dig_q : (dig_q == GW'(DIGITS - 1)) ? '0 : dig_q + GW'(1);

  always_ff @(posedge clk) begin
    if (reset_btn) begin
      state_q       <= S_IDLE;
      s1_q          <= '0;
      s2_q          <= '0;
      s3_q          <= '0;
      e_q           <= '0;
      lfsr_q        <= 16'hACE1;
      pre_q         <= '0;
      ref_q         <= '0;
      dig_q         <= '0;
      delay_q       <= '0;
      cur_q         <= '0;
      best_q        <= ALL9;
      best_valid_q  <= 1'b0;
      led_q         <= 1'b0;
      winner_q      <= '0;
      false_start_q <= 1'b0;
      seg_q         <= SEG_RST;
      an_q          <= AN_RST;
    end else begin
      state_q       <= state_d;
      s1_q          <= {react_btn, start_btn};
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      e_q           <= s2_q & ~s3_q;
      lfsr_q        <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      pre_q         <= pre_d;
      ref_q         <= ref_d;
      dig_q         <= dig_d;
      delay_q       <= delay_d;
      cur_q         <= cur_d;
      best_q        <= best_d;
      best_valid_q  <= best_valid_d;
      led_q         <= led_d;
      winner_q      <= winner_d;
      false_start_q <= false_start_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  // BCD ripple increment; saturation at all nines is handled by the caller
  always_comb begin
    cur_inc = cur_q;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        cur_inc[4*i+:4] = (cur_q[4*i+:4] == 4'd9) ? 4'd0 : cur_q[4*i+:4] + 4'd1;
        carry = cur_q[4*i+:4] == 4'd9;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    pre_d         = tick ? '0 : pre_q + PW'(1);
    delay_d       = delay_q;
    cur_d         = cur_q;
    best_d        = best_q;
    best_valid_d  = best_valid_q;
    led_d         = led_q;
    winner_d      = winner_q;
    false_start_d = false_start_q;
    case (state_q)
      S_WAIT: begin
        if (|react_e) begin
          state_d       = S_FOUL;
          winner_d      = first;
          false_start_d = 1'b1;
          pre_d         = '0;
          delay_d       = BLINK_MS;
        end else if (tick) begin
          if (delay_q <= DW'(1)) begin
            state_d = S_GO;
            led_d   = 1'b1;
            cur_d   = '0;
            pre_d   = '0;
          end else begin
            delay_d = delay_q - DW'(1);
          end
        end
      end
      S_GO: begin
        if (|react_e) begin
          state_d  = S_RESULT;
          winner_d = first;
          led_d    = 1'b0;
          if (cur_q < best_q) begin
            best_d       = cur_q;
            best_valid_d = 1'b1;
          end
        end else if (tick && cur_q != ALL9) begin
          cur_d = cur_inc;
        end
      end
      S_FOUL: begin
        if (tick) begin
          led_d   = (delay_q <= DW'(1)) ? ~led_q : led_q;
          delay_d = (delay_q <= DW'(1)) ? BLINK_MS : delay_q - DW'(1);
        end
      end
      default: ;
    endcase
    // a start edge only counts while no round is running
    if (start_e && state_q != S_WAIT && state_q != S_GO) begin
      state_d       = S_WAIT;
      delay_d       = DW'(MIN_DELAY_MS) + DW'(lfsr_q[RAND_BITS-1:0]);
      pre_d         = '0;
      led_d         = 1'b0;
      winner_d      = '0;
      false_start_d = 1'b0;
    end
  end

  assign show_sel = show_best && (state_q == S_IDLE || state_q == S_RESULT);
  assign dash = state_q == S_FOUL || (show_sel && !best_valid_q);
  assign disp = show_sel ? best_q : cur_q;
  assign nib = 4'(disp >> (4 * dig_q));

  always_comb begin
    case (nib)
      4'd0:    seg_hi = 7'h3F;
      4'd1:    seg_hi = 7'h06;
      4'd2:    seg_hi = 7'h5B;
      4'd3:    seg_hi = 7'h4F;
      4'd4:    seg_hi = 7'h66;
      4'd5:    seg_hi = 7'h6D;
      4'd6:    seg_hi = 7'h7D;
      4'd7:    seg_hi = 7'h07;
      4'd8:    seg_hi = 7'h7F;
      4'd9:    seg_hi = 7'h6F;
      default: seg_hi = 7'h00;
    endcase
  end

  assign seg_d = {7{AL}} ^ (dash ? 7'h40 : seg_hi);
  assign an_d = {DIGITS{AL}} ^ (DIGITS'(1) << dig_q);

  assign led = led_q;
  assign seg = seg_q;
  assign an = an_q;
  assign winner = winner_q;
  assign false_start = false_start_q;
  assign best_valid = best_valid_q;
endmodule

// File: tb/tb_reaction_timer_multi.sv
// tb_reaction_timer_multi: directed scenario bench for reaction_timer_multi at 4 clk per ms.
module tb_reaction_timer_multi;
  logic       clk = 1'b0;
  logic       reset_btn = 1'b1;
  logic       start_btn = 1'b0;
  logic [1:0] react_btn = 2'b00;
  logic       show_best = 1'b0;
  logic       led, false_start, best_valid;
  logic [6:0] seg;
  logic [3:0] an;
  logic [1:0] winner;
  logic [15:0] lfsr_m;
  logic [2:0] last_r;
  int checks = 0;
  int errors = 0;

  reaction_timer_multi #(
    .CLK_HZ(4000), .NUM_PLAYERS(2), .DIGITS(4), .MIN_DELAY_MS(2),
    .RAND_BITS(3), .REFRESH_DIV(4), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_btn(reset_btn), .start_btn(start_btn), .react_btn(react_btn),
    .show_best(show_best), .led(led), .seg(seg), .an(an), .winner(winner),
    .false_start(false_start), .best_valid(best_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always @(posedge clk) lfsr_m <= reset_btn ? 16'hACE1 : step(lfsr_m);

  // active-low seg[6:0] = g..a; dash reads as F, anything unknown as E
  function automatic logic [3:0] seg2d(input logic [6:0] s);
    case (s)
      7'b1000000: return 4'h0;
      7'b1111001: return 4'h1;
      7'b0100100: return 4'h2;
      7'b0110000: return 4'h3;
      7'b0011001: return 4'h4;
      7'b0010010: return 4'h5;
      7'b0000010: return 4'h6;
      7'b1111000: return 4'h7;
      7'b0000000: return 4'h8;
      7'b0010000: return 4'h9;
      7'b0111111: return 4'hF;
      default:    return 4'hE;
    endcase
  endfunction

  task automatic read_disp(output logic [15:0] v);
    logic [3:0] m;
    v = 16'hEEEE;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      for (int d = 0; d < 4; d++) begin
        m = 4'b0001 << d;
        if (an == ~m) v[4*d+:4] = seg2d(seg);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // waits until the FSM will sample LFSR low bits of 5, then pulses start; returns one unit after the FSM leaves IDLE
  task automatic do_start();
    logic [15:0] p;
    p = step(step(step(lfsr_m)));
    for (int i = 0; i < 300 && p[2:0] != 3'd5; i++) begin
      @(posedge clk);
      #1;
      p = step(step(step(lfsr_m)));
    end
    last_r = p[2:0];
    start_btn = 1'b1;
    repeat (2) @(posedge clk);
    #1 start_btn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_go(output int n);
    n = 0;
    while (led !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // from one unit after led rose: the press lands mid-way into ms number ms+1
  task automatic press(input logic [1:0] m, input int ms);
    repeat (4 * ms - 2) @(posedge clk);
    #1 react_btn = m;
    repeat (4) @(posedge clk);
    #1 react_btn = 2'b00;
  endtask

  task automatic test_reset();
    logic [3:0] an_exp [0:4];
    an_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    reset_btn = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_btn = 1'b0;
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led got %b exp 0", led); end
    checks++; if (winner !== 2'b00) begin errors++; $display("FAIL reset_winner got %b exp 00", winner); end
    checks++; if (false_start !== 1'b0) begin errors++; $display("FAIL reset_false_start got %b exp 0", false_start); end
    checks++; if (best_valid !== 1'b0) begin errors++; $display("FAIL reset_best_valid got %b exp 0", best_valid); end
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset_an got %b exp 1110", an); end
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg got %b exp 1000000", seg); end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k % 4 == 2) begin
        checks++; if (an !== an_exp[k/4]) begin errors++; $display("FAIL idle_an k=%0d got %b exp %b", k, an, an_exp[k/4]); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL idle_seg k=%0d got %b exp 1000000", k, seg); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL idle_led k=%0d got %b exp 0", k, led); end
      end
    end
  endtask

  task automatic test_first_round();
    int n;
    logic [15:0] v;
    do_start();
    wait_go(n);
    checks++; if (n != (2 + int'(last_r)) * 4) begin errors++; $display("FAIL go_delay1 got %0d exp %0d", n, (2 + int'(last_r)) * 4); end
    press(2'b01, 37);
    checks++; if (winner !== 2'b01) begin errors++; $display("FAIL winner1 got %b exp 01", winner); end
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL led_off1 got %b exp 0", led); end
    checks++; if (best_valid !== 1'b1) begin errors++; $display("FAIL best_valid1 got %b exp 1", best_valid); end
    read_disp(v);
    checks++; if (v !== 16'h0037) begin errors++; $display("FAIL time1 got %h exp 0037", v); end
    show_best = 1'b1;
    read_disp(v);
    show_best = 1'b0;
    checks++; if (v !== 16'h0037) begin errors++; $display("FAIL best1 got %h exp 0037", v); end
  endtask

  task automatic test_false_start();
    int n;
    logic [15:0] v;
    do_start();
    react_btn = 2'b10;
    repeat (4) @(posedge clk);
    #1 react_btn = 2'b00;
    checks++; if (false_start !== 1'b1) begin errors++; $display("FAIL foul_flag got %b exp 1", false_start); end
    checks++; if (winner !== 2'b10) begin errors++; $display("FAIL foul_winner got %b exp 10", winner); end
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL foul_led got %b exp 0", led); end
    show_best = 1'b1;
    read_disp(v);
    show_best = 1'b0;
    checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL foul_dashes got %h exp FFFF", v); end
    n = 0;
    while (led !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
    checks++; if (led !== 1'b1) begin errors++; $display("FAIL foul_blink_on got %b exp 1", led); end
    n = 0;
    while (led !== 1'b0 && n < 2000) begin @(posedge clk); #1; n++; end
    checks++; if (n != 1000) begin errors++; $display("FAIL foul_blink_period got %0d exp 1000", n); end
    do_start();
    checks++; if (false_start !== 1'b0) begin errors++; $display("FAIL foul_clear_flag got %b exp 0", false_start); end
    checks++; if (winner !== 2'b00) begin errors++; $display("FAIL foul_clear_winner got %b exp 00", winner); end
    wait_go(n);
    checks++; if (n != (2 + int'(last_r)) * 4) begin errors++; $display("FAIL go_delay2 got %0d exp %0d", n, (2 + int'(last_r)) * 4); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    press(2'b11, 50);
    checks++; if (winner !== 2'b01) begin errors++; $display("FAIL simul_winner got %b exp 01", winner); end
    read_disp(v);
    checks++; if (v !== 16'h0050) begin errors++; $display("FAIL time2 got %h exp 0050", v); end
    show_best = 1'b1;
    read_disp(v);
    show_best = 1'b0;
    checks++; if (v !== 16'h0037) begin errors++; $display("FAIL best_kept got %h exp 0037", v); end
  endtask

  task automatic test_best_update();
    int n;
    logic [15:0] v;
    do_start();
    wait_go(n);
    checks++; if (n != (2 + int'(last_r)) * 4) begin errors++; $display("FAIL go_delay3 got %0d exp %0d", n, (2 + int'(last_r)) * 4); end
    press(2'b10, 12);
    checks++; if (winner !== 2'b10) begin errors++; $display("FAIL winner3 got %b exp 10", winner); end
    show_best = 1'b1;
    read_disp(v);
    show_best = 1'b0;
    checks++; if (v !== 16'h0012) begin errors++; $display("FAIL best3 got %h exp 0012", v); end
  endtask

  task automatic test_saturate_reset();
    int n;
    logic [15:0] v;
    do_start();
    wait_go(n);
    checks++; if (n != (2 + int'(last_r)) * 4) begin errors++; $display("FAIL go_delay4 got %0d exp %0d", n, (2 + int'(last_r)) * 4); end
    repeat (40000) @(posedge clk);
    #1;
    read_disp(v);
    checks++; if (v !== 16'h9999) begin errors++; $display("FAIL saturate got %h exp 9999", v); end
    repeat (200) @(posedge clk);
    #1;
    read_disp(v);
    checks++; if (v !== 16'h9999) begin errors++; $display("FAIL no_wrap got %h exp 9999", v); end
    checks++; if (led !== 1'b1) begin errors++; $display("FAIL go_led_held got %b exp 1", led); end
    start_btn = 1'b1;
    @(posedge clk);
    #1 start_btn = 1'b0;
    reset_btn = 1'b1;
    @(posedge clk);
    #1 reset_btn = 1'b0;
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL midreset_led got %b exp 0", led); end
    checks++; if (best_valid !== 1'b0) begin errors++; $display("FAIL midreset_best_valid got %b exp 0", best_valid); end
    checks++; if (winner !== 2'b00) begin errors++; $display("FAIL midreset_winner got %b exp 00", winner); end
    repeat (100) @(posedge clk);
    #1;
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL midreset_no_start got %b exp 0", led); end
    read_disp(v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL midreset_time got %h exp 0000", v); end
    show_best = 1'b1;
    read_disp(v);
    show_best = 1'b0;
    checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL midreset_best got %h exp FFFF", v); end
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_false_start();
    test_back_to_back();
    test_best_update();
    test_saturate_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
